// File: rtl/branch_predict_resolve.sv
// Branch resolution unit with a direct-mapped BTB and saturating direction counters.
// Fetch gets a same-cycle prediction. EX resolution and the redirect are registered.
module branch_predict_resolve #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_BITS    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_pred_taken,
  output logic [XLEN-1:0] f_pred_pc,
  input  logic            ex_valid,
  input  logic            ex_flush,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [6:0]      opcode,
  input  logic [2:0]      func_3,
  input  logic [11:0]     imm_12_i,
  input  logic [11:0]     imm_12_b,
  input  logic [19:0]     imm_20,
  input  logic [XLEN-1:0] rs_1,
  input  logic [XLEN-1:0] rs_2,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_pc,
  output logic            b_valid,
  output logic            b_taken,
  output logic [XLEN-1:0] b_pc,
  output logic [XLEN-1:0] b_link,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  localparam int CNT_WT_I  = 1 << (CNT_BITS - 1);
  localparam int CNT_WNT_I = CNT_WT_I - 1;
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_WT_I[CNT_BITS-1:0];
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WNT_I[CNT_BITS-1:0];
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_MIN = '0;
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
  localparam logic [XLEN-1:0]     FOUR    = XLEN'(4);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // EX handshake: ex_valid qualifies one instruction per cycle, there is no
  // back-pressure, and ex_flush (or rst) kills the instruction in that cycle.

  logic                btb_valid   [BTB_ENTRIES];
  logic [TAG_W-1:0]    btb_tag     [BTB_ENTRIES];
  logic [XLEN-1:0]     btb_target  [BTB_ENTRIES];
  logic                btb_is_jump [BTB_ENTRIES];
  logic [CNT_BITS-1:0] btb_cnt     [BTB_ENTRIES];

  // Fetch-side lookup
  logic [IDX-1:0] f_idx;
  logic           f_hit;

  assign f_idx        = f_pc[IDX+1:2];
  assign f_hit        = btb_valid[f_idx] && (btb_tag[f_idx] == f_pc[XLEN-1:IDX+2]);
  assign f_pred_taken = f_hit && (btb_is_jump[f_idx] || btb_cnt[f_idx][CNT_BITS-1]);
  assign f_pred_pc    = f_pred_taken ? btb_target[f_idx] : '0;

  wire unused_bits = &{1'b0, f_pc[1:0]};

  // EX-side decode and resolution
  logic                acc;
  logic                is_br, is_jal, is_jalr, is_ctrl, br_known;
  logic                taken;
  logic [XLEN-1:0]     target, link;
  logic [XLEN-1:0]     sext_i, sext_b, sext_j, jalr_sum;
  logic                mis;
  logic [IDX-1:0]      e_idx;
  logic                e_hit;
  logic                btb_upd, btb_inval;
  logic [CNT_BITS-1:0] cnt_next;

  assign acc     = ex_valid && !ex_flush && !rst;
  assign is_br   = (opcode == OP_BRANCH);
  assign is_jal  = (opcode == OP_JAL);
  assign is_jalr = (opcode == OP_JALR);
  assign is_ctrl = is_br || is_jal || is_jalr;

  assign sext_i   = {{(XLEN-12){imm_12_i[11]}}, imm_12_i};
  assign sext_b   = {{(XLEN-13){imm_12_b[11]}}, imm_12_b, 1'b0};
  assign sext_j   = {{(XLEN-21){imm_20[19]}}, imm_20, 1'b0};
  assign jalr_sum = rs_1 + sext_i;
  assign link     = ex_pc + FOUR;

  always_comb begin
    taken    = 1'b0;
    target   = ex_pc + sext_b;
    br_known = 1'b1;
    if (is_jal) begin
      target = ex_pc + sext_j;
      taken  = 1'b1;
    end else if (is_jalr) begin
      target = {jalr_sum[XLEN-1:1], 1'b0};
      taken  = 1'b1;
    end else if (is_br) begin
      case (func_3)
        3'b000:  taken = (rs_1 == rs_2);
        3'b001:  taken = (rs_1 != rs_2);
        3'b100:  taken = ($signed(rs_1) <  $signed(rs_2));
        3'b101:  taken = ($signed(rs_1) >= $signed(rs_2));
        3'b110:  taken = (rs_1 <  rs_2);
        3'b111:  taken = (rs_1 >= rs_2);
        default: br_known = 1'b0;
      endcase
    end
  end

  assign mis = (taken != ex_pred_taken) || (taken && ex_pred_taken && (target != ex_pred_pc));

  assign e_idx     = ex_pc[IDX+1:2];
  assign e_hit     = btb_valid[e_idx] && (btb_tag[e_idx] == ex_pc[XLEN-1:IDX+2]);
  assign btb_upd   = acc && (is_jal || is_jalr || (is_br && br_known));
  assign btb_inval = acc && !is_ctrl && ex_pred_taken;

  always_comb begin
    cnt_next = btb_cnt[e_idx];
    if (taken) begin
      if (btb_cnt[e_idx] != CNT_MAX) cnt_next = btb_cnt[e_idx] + CNT_ONE;
    end else begin
      if (btb_cnt[e_idx] != CNT_MIN) cnt_next = btb_cnt[e_idx] - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]   <= 1'b0;
        btb_tag[i]     <= '0;
        btb_target[i]  <= '0;
        btb_is_jump[i] <= 1'b0;
        btb_cnt[i]     <= CNT_WNT;
      end
      b_valid     <= 1'b0;
      b_taken     <= 1'b0;
      b_pc        <= '0;
      b_link      <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      b_valid    <= 1'b0;
      b_taken    <= 1'b0;
      mispredict <= 1'b0;
      if (acc) begin
        if (is_ctrl) begin
          b_valid     <= 1'b1;
          b_taken     <= taken;
          b_pc        <= target;
          b_link      <= link;
          mispredict  <= mis;
          redirect_pc <= taken ? target : link;
        end else if (ex_pred_taken) begin
          // Fetch predicted a jump on something that is not a control op.
          mispredict  <= 1'b1;
          redirect_pc <= link;
        end
      end
      if (btb_upd) begin
        if (e_hit) begin
          btb_cnt[e_idx]     <= cnt_next;
          btb_target[e_idx]  <= target;
          btb_is_jump[e_idx] <= is_jal || is_jalr;
        end else if (taken) begin
          btb_valid[e_idx]   <= 1'b1;
          btb_tag[e_idx]     <= ex_pc[XLEN-1:IDX+2];
          btb_target[e_idx]  <= target;
          btb_is_jump[e_idx] <= is_jal || is_jalr;
          btb_cnt[e_idx]     <= CNT_WT;
        end
      end
      if (btb_inval) btb_valid[e_idx] <= 1'b0;
    end
  end

endmodule
